reg_access_arbiter: RTL
=======================

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of the write data path.
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, the maximum number of consecutive granted cycles when timeout is compiled in.
REQ-003 The block SHALL have parameter NUM_REGS, default 23, the number of valid register addresses, 0 to NUM_REGS-1.
REQ-004 Ports SHALL be as follows, clock and reset first:
- clk  in  1  system clock; single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- m0_req  in  1  requester 0 access request; held high for the whole burst.
- m0_wr  in  1  requester 0 write strobe.
- m0_addr  in  16  requester 0 register address.
- m0_din  in  DATA_WIDTH  requester 0 write data.
- m0_grant  out  1  requester 0 owns the register port.
- m1_req, m1_wr, m1_addr, m1_din, m1_grant: same widths and meanings for requester 1.
- s_addr  out  16  address to the register-write decoder.
- s_wr  out  1  qualified write strobe to the register-write decoder.
- s_din  out  DATA_WIDTH  write data to the register file.
- addr_err  out  1  one-cycle pulse flagging a suppressed out-of-range write.

Function
REQ-005 The FSM SHALL have exactly three states, IDLE, OWN0 and OWN1, held in a registered state variable.
REQ-006 m0_grant SHALL be 1 exactly in OWN0, and m1_grant SHALL be 1 exactly in OWN1; both are registered state decodes and are never 1 together.
REQ-007 The FSM SHALL move from IDLE to OWN0 when only m0_req=1, and to OWN1 when only m1_req=1, so grant rises on the cycle after req is first sampled high.
REQ-008 When both requests are high in IDLE, the FSM SHALL grant the requester that is not the last-served requester, held in a 1-bit register last.
REQ-009 In OWNx with mx_req=1, the FSM SHALL stay in OWNx, except as REQ-019 requires.
REQ-010 In OWNx with mx_req=0, the FSM SHALL go to OWNy if the other requester's request is high, otherwise to IDLE; grant therefore hands over with no idle cycle between requesters.
REQ-011 The register last SHALL be updated to x on every cycle spent in OWNx.
REQ-012 In OWNx, s_addr and s_din SHALL equal mx_addr and mx_din combinationally; in IDLE, s_addr=0 and s_din=0.
REQ-013 s_wr SHALL be 1 only when the state is OWNx, mx_req=1, mx_wr=1 and mx_addr < NUM_REGS.
REQ-014 In the cycle after any cycle with state OWNx, mx_req=1, mx_wr=1 and mx_addr >= NUM_REGS, addr_err SHALL be 1 for one cycle, and s_wr SHALL have been 0 in the offending cycle.
REQ-015 Address comparison SHALL use all 16 address bits, unsigned; 0xFFFF is out of range.
REQ-016 A request or write strobe from a requester that is not granted SHALL have no effect on s_addr, s_din or s_wr.
REQ-017 Write latency SHALL be zero cycles from a granted, in-range wr to s_wr; one s_wr pulse is produced per clock cycle that meets REQ-013.

Reset
REQ-018 When reset_n=0 at a rising edge, the block SHALL set state=IDLE, last=1 (so requester 0 wins the first tie), hold counter=0, addr_err=0, m0_grant=0 and m1_grant=0; s_addr, s_din and s_wr then read 0. Reset asserted mid-burst SHALL drop the grant on that edge, and no s_wr SHALL occur in the cycle after it.

Configuration
REQ-019 With macro ARB_TIMEOUT_EN defined, a hold counter SHALL behave as follows:
- It counts consecutive cycles in the same OWN state and clears on any state change.
- When the counter equals MAX_HOLD-1 and the other requester's request is high, the FSM SHALL move directly to the other OWN state, even though mx_req is still 1.
- The preempted requester SHALL see its grant fall and must re-arbitrate.
- With the other request low, the counter SHALL saturate at MAX_HOLD-1 and ownership continues.
REQ-020 Without ARB_TIMEOUT_EN, the block SHALL contain no counter and no preemption; a burst holds the grant for as long as its request stays high.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Reset release, m0_req=1, m0_wr=1, m0_addr=5, m0_din=0xA5A5A5A5 -> m0_grant=1 on the next cycle, then s_wr=1, s_addr=5, s_din=0xA5A5A5A5 every cycle.
- m0_req and m1_req rise in the same cycle after reset -> OWN0 first; when m0_req drops, m1_grant=1 on the next edge with no IDLE cycle; a later tie goes to requester 1 only if last=0.
- Granted m1 write with m1_addr=23, then m1_addr=22 -> s_wr=0 and addr_err pulses for one cycle, then s_wr=1 with s_addr=22.
- m1_wr=1 with m1_req=1 while m0 is granted -> s_wr follows m0 only; s_addr never shows m1_addr.
- ARB_TIMEOUT_EN defined, MAX_HOLD=4, m0 holds req with m1_req=1 -> m0_grant high exactly 4 cycles, then m1_grant=1; without the macro, m0_grant stays high indefinitely.
- reset_n=0 for one cycle mid-burst in OWN1 -> grants 0, s_wr 0 on the next cycle; re-arbitration grants m0 first on a tie.

Source files
------------

// File: rtl/reg_access_arbiter.sv
// Two-requester register-port arbiter: alternating tie-break, range-checked writes.
// Define ARB_TIMEOUT_EN to add the MAX_HOLD hold counter that preempts long bursts.
module reg_access_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 16,
    parameter int NUM_REGS   = 23
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [15:0]           m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_din,
    output logic                  m0_grant,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [15:0]           m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_din,
    output logic                  m1_grant,
    output logic [15:0]           s_addr,
    output logic                  s_wr,
    output logic [DATA_WIDTH-1:0] s_din,
    output logic                  addr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // 17-bit compare keeps the full unsigned 16-bit address range in play.
    localparam logic [16:0] NREGS = 17'(NUM_REGS);

    state_t                  state_q, state_d;
    logic                    last_q;
    logic                    m0_grant_q, m1_grant_q;
    logic                    addr_err_q, addr_err_d;
    logic                    sel_req, sel_wr, in_range;
    logic [15:0]             sel_addr;
    logic [DATA_WIDTH-1:0]   sel_din;
    logic                    timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int          HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0]      hold_q;

    assign timeout = (hold_q == HOLD_MAX);
`else
    assign timeout = 1'b0;
`endif

    // Datapath follows whichever requester owns the port; IDLE drives zeros.
    always_comb begin
        sel_req  = 1'b0;
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        case (state_q)
            OWN0: begin
                sel_req  = m0_req;
                sel_wr   = m0_wr;
                sel_addr = m0_addr;
                sel_din  = m0_din;
            end
            OWN1: begin
                sel_req  = m1_req;
                sel_wr   = m1_wr;
                sel_addr = m1_addr;
                sel_din  = m1_din;
            end
            default: ;
        endcase
    end

    assign in_range   = ({1'b0, sel_addr} < NREGS);
    assign addr_err_d = sel_req & sel_wr & ~in_range;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req)
                    state_d = last_q ? OWN0 : OWN1;
                else if (m0_req)
                    state_d = OWN0;
                else if (m1_req)
                    state_d = OWN1;
            end
            OWN0: begin
                if (!m0_req)
                    state_d = m1_req ? OWN1 : IDLE;
                else if (timeout && m1_req)
                    state_d = OWN1;
            end
            OWN1: begin
                if (!m1_req)
                    state_d = m0_req ? OWN0 : IDLE;
                else if (timeout && m0_req)
                    state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            m0_grant_q <= 1'b0;
            m1_grant_q <= 1'b0;
            addr_err_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            m0_grant_q <= (state_d == OWN0);
            m1_grant_q <= (state_d == OWN1);
            addr_err_q <= addr_err_d;
            if (state_q == OWN0)
                last_q <= 1'b0;
            else if (state_q == OWN1)
                last_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            // Counts cycles spent in one OWN state; saturates when uncontested.
            if (state_d != state_q || state_d == IDLE)
                hold_q <= '0;
            else if (hold_q != HOLD_MAX)
                hold_q <= hold_q + 1'b1;
`endif
        end
    end

    assign m0_grant = m0_grant_q;
    assign m1_grant = m1_grant_q;
    assign s_addr   = sel_addr;
    assign s_din    = sel_din;
    assign s_wr     = sel_req & sel_wr & in_range;
    assign addr_err = addr_err_q;

endmodule
